// File: rtl/register_bank.sv
// register_bank: addressed bank of general-purpose registers with in-place
// increment / decrement / clear, a registered wrap flag, a gated bus read
// port (drives zero when not enabled) and an ungated display read port.
module register_bank #(
  parameter int width      = 16,
  parameter int depth      = 8,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [1:0]            op,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [width-1:0]      in,
  input  logic                  oe,
  input  logic [addr_width-1:0] rd_addr,
  output logic [width-1:0]      out,
  input  logic [addr_width-1:0] disp_addr,
  output logic [width-1:0]      disp_out,
  output logic                  wrap,
  output logic                  zero
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic [depth-1:0][width-1:0] regs_q, regs_d;
  logic                        wrap_q, wrap_d;

  logic [depth-1:0] wr_sel;
  logic             wr_hit;
  logic [width-1:0] wr_cur, wr_new;
  logic [width-1:0] rd_val, disp_val;

  // Decode the write address; an out-of-range address selects no register,
  // which is what makes such a write a complete no-op (wrap included).
  always_comb begin
    wr_sel = '0;
    wr_cur = '0;
    for (int i = 0; i < depth; i++) begin
      if (wr_addr == addr_width'(i)) begin
        wr_sel[i] = 1'b1;
        wr_cur    = regs_q[i];
      end
    end
  end

  assign wr_hit = we & (|wr_sel);

  // Compute the new value of the targeted register and the wrap outcome.
  always_comb begin
    wr_new = wr_cur;
    wrap_d = wrap_q;
    case (op)
      OP_LOAD: wr_new = in;
      OP_INC:  wr_new = wr_cur + ONE;
      OP_DEC:  wr_new = wr_cur - ONE;
      OP_CLR:  wr_new = '0;
      default: wr_new = wr_cur;
    endcase
    if (wr_hit)
      wrap_d = ((op == OP_INC) && (&wr_cur)) || ((op == OP_DEC) && ~(|wr_cur));
  end

  // Only the selected register takes the new value; all others hold.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < depth; i++) begin
      if (we && wr_sel[i]) regs_d[i] = wr_new;
    end
  end

  // State update; reset clears every register and the wrap flag at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  // Combinational read muxes; out-of-range addresses fall through to zero.
  always_comb begin
    rd_val   = '0;
    disp_val = '0;
    for (int i = 0; i < depth; i++) begin
      if (rd_addr   == addr_width'(i)) rd_val   = regs_q[i];
      if (disp_addr == addr_width'(i)) disp_val = regs_q[i];
    end
  end

  // Bus port is zero when disabled so several sources can be OR-combined.
  assign out      = oe ? rd_val : '0;
  assign disp_out = disp_val;
  assign zero     = (rd_val == '0);
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank; depth=6 so addresses 6/7 are out of range.
module tb_register_bank;
  localparam int W  = 16;
  localparam int D  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0, oe = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0, disp_addr = '0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout, disp_out;
  logic          wrap, zero;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  register_bank #(.width(W), .depth(D), .addr_width(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .op(op), .wr_addr(wr_addr), .in(din),
    .oe(oe), .rd_addr(rd_addr), .out(dout), .disp_addr(disp_addr),
    .disp_out(disp_out), .wrap(wrap), .zero(zero)
  );

  task automatic push(input string t, input logic [W-1:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [W-1:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [W-1:0] d);
    we = w; op = o; wr_addr = a; din = d;
  endtask

  initial begin
    // Reset held from time 0
    oe = 1'b1; rd_addr = 3'd0; #3;
    push("rst0_out", '0);  chk(dout);
    push("rst0_zero", 16'd1); chk({15'd0, zero});
    push("rst0_wrap", '0); chk({15'd0, wrap});
    tick(); rst = 1'b0;

    // Give the bank some state, then reset asynchronously mid-cycle
    drive(1'b1, 2'b00, 3'd0, 16'hAAAA); tick();
    drive(1'b1, 2'b10, 3'd5, 16'h0000); tick();
    disp_addr = 3'd5; #1;
    push("pre_wrap", 16'd1);     chk({15'd0, wrap});
    push("pre_disp", 16'hFFFF);  chk(disp_out);
    push("pre_r0", 16'hAAAA);    chk(dout);
    drive(1'b1, 2'b00, 3'd5, 16'h1111);
    #2 rst = 1'b1; #1;
    push("arst_out", '0);       chk(dout);
    push("arst_disp", '0);      chk(disp_out);
    push("arst_wrap", '0);      chk({15'd0, wrap});
    push("arst_zero", 16'd1);   chk({15'd0, zero});
    tick();
    push("arst_hold", '0);      chk(disp_out);
    rst = 1'b0; we = 1'b0; tick();

    // Load / read, gated bus vs ungated display
    drive(1'b1, 2'b00, 3'd3, 16'h1234); push("ld_r3", 16'h1234); tick();
    we = 1'b0; rd_addr = 3'd3; oe = 1'b1; #1; chk(dout);
    oe = 1'b0; disp_addr = 3'd3; #1;
    push("oe0_out", '0);        chk(dout);
    push("oe0_disp", 16'h1234); chk(disp_out);
    push("oe0_zero", '0);       chk({15'd0, zero});

    // Increment across the wrap point
    drive(1'b1, 2'b00, 3'd1, 16'hFFFE); tick();
    drive(1'b1, 2'b01, 3'd1, 16'h0000);
    push("inc1", 16'hFFFF); push("inc1_wrap", '0); tick();
    disp_addr = 3'd1; #1; chk(disp_out); chk({15'd0, wrap});
    push("inc2", '0); push("inc2_wrap", 16'd1); push("inc2_zero", 16'd1); tick();
    rd_addr = 3'd1; #1; chk(disp_out); chk({15'd0, wrap}); chk({15'd0, zero});
    we = 1'b0; push("idle_wrap", 16'd1); tick(); chk({15'd0, wrap});

    // Decrement from zero, then load and clear
    drive(1'b1, 2'b10, 3'd2, 16'h0000);
    push("dec0", 16'hFFFF); push("dec0_wrap", 16'd1); tick();
    disp_addr = 3'd2; #1; chk(disp_out); chk({15'd0, wrap});
    drive(1'b1, 2'b00, 3'd2, 16'h0005);
    push("ld5", 16'h0005); push("ld5_wrap", '0); tick(); chk(disp_out); chk({15'd0, wrap});
    drive(1'b1, 2'b11, 3'd2, 16'hFFFF);
    push("clr", '0); push("clr_wrap", '0); tick(); chk(disp_out); chk({15'd0, wrap});
    drive(1'b1, 2'b10, 3'd3, 16'h0000);
    push("dec_r3", 16'h1233); push("dec_r3_wrap", '0); tick();
    disp_addr = 3'd3; #1; chk(disp_out); chk({15'd0, wrap});

    // Same-cycle read of the register being written: no bypass
    drive(1'b1, 2'b00, 3'd4, 16'h0007); tick();
    drive(1'b1, 2'b00, 3'd4, 16'h0009); rd_addr = 3'd4; oe = 1'b1; #1;
    push("rw_before", 16'h0007); chk(dout);
    push("rw_after", 16'h0009); tick(); chk(dout);
    push("rw_other", 16'h1233); chk(disp_out);

    // Out-of-range writes and reads
    drive(1'b1, 2'b10, 3'd2, 16'h0000); tick();
    drive(1'b1, 2'b11, 3'd7, 16'h0000);
    push("oor_wrap", 16'd1); tick(); chk({15'd0, wrap});
    drive(1'b1, 2'b00, 3'd6, 16'hBEEF);
    push("oor_wrap2", 16'd1); tick(); chk({15'd0, wrap});
    we = 1'b0;
    for (int i = 0; i < D; i++) begin
      logic [W-1:0] ev;
      case (i)
        1: ev = 16'h0000; 2: ev = 16'hFFFF; 3: ev = 16'h1233;
        4: ev = 16'h0009; default: ev = 16'h0000;
      endcase
      disp_addr = AW'(i); push($sformatf("oor_keep_r%0d", i), ev); #1; chk(disp_out);
    end
    rd_addr = 3'd7; oe = 1'b1; disp_addr = 3'd6; #1;
    push("oor_rd_out", '0);     chk(dout);
    push("oor_rd_zero", 16'd1); chk({15'd0, zero});
    push("oor_disp", '0);       chk(disp_out);

    if (sb.size() != 0) begin
      checks++; failures++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of `depth` general-purpose registers for the didactic computer datapath. It is the next generation of the single bus register. It adds addressed write and read ports and in-place increment, decrement and clear operations, for use as address, stack or counter registers. It also provides a wrap flag and an independent display read port. It sits on the internal data bus: a tri-state-free read port drives zero when not enabled, so bus outputs can be OR-combined.

## Interface
- `width`, 16: bits per register.
- `depth`, 8: number of registers; must be ≥ 2.
- `addr_width`, 3: address bits; must satisfy 2^`addr_width` ≥ `depth`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `we`  in  1  write/operation enable.
- `op`  in  2  operation applied to `wr_addr` when `we`=1: 00 load, 01 increment, 10 decrement, 11 clear.
- `wr_addr`  in  `addr_width`  target register of the operation.
- `in`  in  `width`  load data; used only for op 00.
- `oe`  in  1  bus output enable.
- `rd_addr`  in  `addr_width`  register driven onto `out`.
- `out`  out  `width`  register `rd_addr` when `oe`=1, else 0.
- `disp_addr`  in  `addr_width`  register shown on `disp_out`.
- `disp_out`  out  `width`  register `disp_addr`, unconditionally; not gated by `oe`.
- `wrap`  out  1  registered; 1 when the last executed operation wrapped.
- `zero`  out  1  combinational; 1 when register `rd_addr` equals 0, independent of `oe`.

## Operation
- Storage is `depth` registers of `width` bits, plus the `wrap` flip-flop.
- With `we`=1 and `wr_addr` < `depth`, the rising edge updates register `wr_addr`:
  - load: value becomes `in`.
  - increment: value becomes value + 1, modulo 2^`width`.
  - decrement: value becomes value − 1, modulo 2^`width`.
  - clear: value becomes 0.
- `wrap` is loaded on every edge with `we`=1 and a valid address:
  - 1 for increment of all-ones (result 0).
  - 1 for decrement of 0 (result all-ones).
  - 0 for every other operation or value.
- `wrap` holds its value on edges with `we`=0.
- Out-of-range addresses (≥ `depth`):
  - A write with `wr_addr` out of range changes no register and leaves `wrap` unchanged.
  - An out-of-range `rd_addr` or `disp_addr` reads as 0.
  - `zero` is 1 for an out-of-range `rd_addr`.
- Registers other than `wr_addr` always hold their value.
- Only one write port exists, so no write conflicts are possible.

## Timing
- Reset: while `rst`=1, independent of `clk`, all registers are 0 and `wrap`=0.
  - Consequently `out`=0, `disp_out`=0 and `zero`=1.
  - Reset asserted mid-operation discards any pending update.
  - The first edge after `rst` deasserts behaves normally.
- Write latency is one cycle: the new value is visible on `out`/`disp_out` after the rising edge.
- Reads are combinational from `rd_addr`, `disp_addr` and `oe`; there is no read latency.
- A read of the address being written in the same cycle returns the old value until the edge. There is no bypass.
- `wrap` changes only on an edge.
- `zero` follows the register contents combinationally.

## Test plan
- Reset: drive values, assert `rst` asynchronously between edges → immediately all regs 0, `wrap`=0, `out`=0, `zero`=1.
- Load/read: load 0x1234 to r3, then `rd_addr`=3, `oe`=1 → `out`=0x1234. Same with `oe`=0 → `out`=0 while `disp_addr`=3 gives `disp_out`=0x1234.
- Increment wrap: load 0xFFFE to r1, inc → 0xFFFF, `wrap`=0. Inc again → 0x0000, `wrap`=1, `zero`=1. Idle cycle with `we`=0 → `wrap` stays 1.
- Decrement wrap then clear: dec r2 from 0 → 0xFFFF, `wrap`=1. Load r2=5 → `wrap`=0. Clear r2 → r2=0, `wrap`=0.
- Same-cycle read/write: `rd_addr`=`wr_addr`=4, r4=7, load 9 → `out`=7 before the edge and 9 after. Other registers unchanged throughout.
- Out-of-range with `depth`=6: write to address 7 → no register changes and `wrap` holds. `rd_addr`=7 → `out`=0, `zero`=1.
